// File: rtl/gshare_pred.sv
// gshare branch direction predictor: PC^GHR indexed saturating counters, speculative
// history shift at lookup, repair from a carried GHR snapshot. Optional PRED_STATS_EN adds counters.
module gshare_pred #(
    parameter int GHRWIDTH = 8,
    parameter int PCWIDTH  = 32,
    parameter int CTRWIDTH = 2,
    parameter int PC_LSB   = 2
) (
    input  logic                clk,
    input  logic                async_rst_n,
    input  logic                clk_en,
    input  logic                lkp_valid,
    input  logic [PCWIDTH-1:0]  lkp_pc,
    output logic                pred_valid,
    output logic                prediction,
    output logic [GHRWIDTH-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [PCWIDTH-1:0]  upd_pc,
    input  logic [GHRWIDTH-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_mispredict
`ifdef PRED_STATS_EN
    ,
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int DEPTH = 1 << GHRWIDTH;
    localparam logic [CTRWIDTH-1:0] CTR_INIT = CTRWIDTH'((1 << (CTRWIDTH - 1)) - 1);
    localparam logic [CTRWIDTH-1:0] CTR_MAX  = {CTRWIDTH{1'b1}};

    logic [GHRWIDTH-1:0]               ghr_reg;
    logic [GHRWIDTH-1:0]               ghr_next;
    logic [DEPTH-1:0][CTRWIDTH-1:0]    ctr_flat;

    logic [GHRWIDTH-1:0] lkp_idx;
    logic [GHRWIDTH-1:0] upd_idx;
    logic [CTRWIDTH-1:0] upd_ctr_cur;
    logic [CTRWIDTH-1:0] upd_ctr_next;
    logic [CTRWIDTH-1:0] lkp_ctr;
    logic                lkp_bit;

    logic                pred_valid_reg;
    logic                prediction_reg;
    logic [GHRWIDTH-1:0] pred_ghr_reg;

    // PC bits outside the index window are intentionally ignored.
    wire unused_pc_bits = &{1'b0, lkp_pc, upd_pc};

    assign lkp_idx     = lkp_pc[PC_LSB +: GHRWIDTH] ^ ghr_reg;
    assign upd_idx     = upd_pc[PC_LSB +: GHRWIDTH] ^ upd_ghr;
    assign upd_ctr_cur = ctr_flat[upd_idx];

    always_comb begin
        upd_ctr_next = upd_ctr_cur;
        if (upd_taken) begin
            if (upd_ctr_cur != CTR_MAX) upd_ctr_next = upd_ctr_cur + CTRWIDTH'(1);
        end else begin
            if (upd_ctr_cur != '0) upd_ctr_next = upd_ctr_cur - CTRWIDTH'(1);
        end
    end

    // Write-first: a same-cycle update to the looked-up entry is visible to the lookup.
    assign lkp_ctr = (upd_valid && (upd_idx == lkp_idx)) ? upd_ctr_next : ctr_flat[lkp_idx];
    assign lkp_bit = lkp_ctr[CTRWIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ctr
            logic [CTRWIDTH-1:0] cell_reg;

            always_ff @(posedge clk or negedge async_rst_n) begin
                if (!async_rst_n) begin
                    cell_reg <= CTR_INIT;
                end else if (clk_en && upd_valid && (upd_idx == GHRWIDTH'(gi))) begin
                    cell_reg <= upd_ctr_next;
                end
            end

            assign ctr_flat[gi] = cell_reg;
        end
    endgenerate

    // Repair outranks the speculative shift; a concurrent lookup's shift is discarded.
    always_comb begin
        ghr_next = ghr_reg;
        if (upd_valid && upd_mispredict) begin
            ghr_next = {upd_ghr[GHRWIDTH-2:0], upd_taken};
        end else if (lkp_valid) begin
            ghr_next = {ghr_reg[GHRWIDTH-2:0], lkp_bit};
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            ghr_reg        <= '0;
            pred_valid_reg <= 1'b0;
            prediction_reg <= 1'b0;
            pred_ghr_reg   <= '0;
        end else if (clk_en) begin
            ghr_reg        <= ghr_next;
            pred_valid_reg <= lkp_valid;
            if (lkp_valid) begin
                prediction_reg <= lkp_bit;
                pred_ghr_reg   <= ghr_reg;
            end
        end
    end

    assign pred_valid = pred_valid_reg;
    assign prediction = prediction_reg;
    assign pred_ghr   = pred_ghr_reg;

`ifdef PRED_STATS_EN
    logic [31:0] stat_lookups_reg;
    logic [31:0] stat_mispredicts_reg;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            stat_lookups_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else if (clk_en) begin
            if (lkp_valid && (stat_lookups_reg != 32'hFFFF_FFFF))
                stat_lookups_reg <= stat_lookups_reg + 32'd1;
            if (upd_valid && upd_mispredict && (stat_mispredicts_reg != 32'hFFFF_FFFF))
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
        end
    end

    assign stat_lookups     = stat_lookups_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_gshare_pred.sv
// Randomised + directed bench for gshare_pred against an arithmetic reference model.
module tb_gshare_pred;
    localparam int GW   = 8;
    localparam int PW   = 32;
    localparam int CW   = 2;
    localparam int LSB  = 2;
    localparam int N    = 1 << GW;
    localparam int MASK = N - 1;
    localparam int CMAX = (1 << CW) - 1;
    localparam int HALF = 1 << (CW - 1);

    logic          clk = 1'b0;
    logic          async_rst_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          lkp_valid = 1'b0;
    logic [PW-1:0] lkp_pc = '0;
    logic          pred_valid;
    logic          prediction;
    logic [GW-1:0] pred_ghr;
    logic          upd_valid = 1'b0;
    logic [PW-1:0] upd_pc = '0;
    logic [GW-1:0] upd_ghr = '0;
    logic          upd_taken = 1'b0;
    logic          upd_mispredict = 1'b0;
`ifdef PRED_STATS_EN
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_mispredicts;
`endif

    gshare_pred #(.GHRWIDTH(GW), .PCWIDTH(PW), .CTRWIDTH(CW), .PC_LSB(LSB)) dut (
        .clk            (clk),
        .async_rst_n    (async_rst_n),
        .clk_en         (clk_en),
        .lkp_valid      (lkp_valid),
        .lkp_pc         (lkp_pc),
        .pred_valid     (pred_valid),
        .prediction     (prediction),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
`ifdef PRED_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int     m_ctr [N];
    int     m_ghr;
    int     m_pv, m_pred, m_pghr;
    longint m_lk, m_mp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [PW-1:0] pc, input int h);
        return (int'(pc >> LSB) & MASK) ^ (h & MASK);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctr[i] = HALF - 1;
        m_ghr = 0; m_pv = 0; m_pred = 0; m_pghr = 0;
        m_lk = 0; m_mp = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pred_valid"}, 32'(pred_valid), 32'(m_pv));
        check({tag, ".prediction"}, 32'(prediction), 32'(m_pred));
        check({tag, ".pred_ghr"},   32'(pred_ghr),   32'(m_pghr));
`ifdef PRED_STATS_EN
        check({tag, ".stat_lookups"},     stat_lookups,     32'(m_lk));
        check({tag, ".stat_mispredicts"}, stat_mispredicts, 32'(m_mp));
`endif
    endtask

    // One clock: drive inputs, advance the model, check after the edge, return at negedge.
    task automatic cycle(input string tag, input bit en, input bit lv, input logic [PW-1:0] lpc,
                         input bit uv, input logic [PW-1:0] upc, input int ughr,
                         input bit ut, input bit um);
        int li, ui, unew, seen;
        clk_en = en; lkp_valid = lv; lkp_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_ghr = GW'(ughr);
        upd_taken = ut; upd_mispredict = um;
        if (en) begin
            li   = idx_of(lpc, m_ghr);
            ui   = idx_of(upc, ughr);
            unew = m_ctr[ui];
            if (uv) unew = ut ? ((m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX)
                              : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
            seen = (uv && ui == li) ? unew : m_ctr[li];
            m_pv = lv;
            if (lv) begin
                m_pred = (seen >= HALF) ? 1 : 0;
                m_pghr = m_ghr;
                if (m_lk < 64'hFFFF_FFFF) m_lk++;
            end
            if (uv) m_ctr[ui] = unew;
            if (uv && um) begin
                m_ghr = ((ughr << 1) | int'(ut)) & MASK;
                if (m_mp < 64'hFFFF_FFFF) m_mp++;
            end else if (lv) begin
                m_ghr = ((m_ghr << 1) | m_pred) & MASK;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic lookup(input string tag, input logic [PW-1:0] pc);
        cycle(tag, 1, 1, pc, 0, '0, 0, 0, 0);
    endtask

    task automatic update(input string tag, input logic [PW-1:0] pc, input int h, input bit t, input bit m);
        cycle(tag, 1, 0, '0, 1, pc, h, t, m);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic mid_reset();
        #2;
        async_rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge clk);
        async_rst_n = 1'b1;
    endtask

    initial begin
        bit en, lv, uv, ut, um;
        logic [PW-1:0] lpc, upc;
        int ughr;

        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        async_rst_n = 1'b1;

        // Reset lookup
        lookup("rst_lookup", 32'h100);
        check("rst_lookup.pv_const", 32'(pred_valid), 32'd1);
        check("rst_lookup.pred_const", 32'(prediction), 32'd0);
        check("rst_lookup.ghr_const", 32'(pred_ghr), 32'h00);

        // Training with saturation, no GHR disturbance
        for (int i = 0; i < 3; i++) update("train0", 32'h100, 0, 1, 0);
        for (int i = 0; i < 2; i++) update("train1", 32'h100, 1, 1, 0);
        for (int i = 0; i < 2; i++) update("train3", 32'h100, 3, 1, 0);
        update("repair0", 32'h200, 0, 0, 1);
        lookup("trained", 32'h100);
        check("trained.pred_const", 32'(prediction), 32'd1);
        check("trained.ghr_const", 32'(pred_ghr), 32'h00);

        // Speculative shift to 0x07, then repair to 0x02
        lookup("spec1", 32'h100);
        lookup("spec2", 32'h100);
        check("spec2.ghr_const", 32'(pred_ghr), 32'h03);
        update("repair_spec", 32'h100, 1, 0, 1);

        // Repair and lookup in the same cycle
        cycle("repair_lkp", 1, 1, 32'h100, 1, 32'h300, 32'h10, 1, 1);
        check("repair_lkp.pv_const", 32'(pred_valid), 32'd1);
        check("repair_lkp.ghr_const", 32'(pred_ghr), 32'h02);
        lookup("after_repair", 32'h100);
        check("after_repair.ghr_const", 32'(pred_ghr), 32'h21);

        // Write-first bypass at weakly not-taken
        update("repair_zero", 32'h200, 0, 0, 1);
        cycle("bypass", 1, 1, 32'h400, 1, 32'h400, 0, 1, 0);
        check("bypass.pred_const", 32'(prediction), 32'd1);

        // clk_en low: everything frozen
        cycle("hold1", 0, 1, 32'h400, 1, 32'h400, 0, 0, 1);
        cycle("hold2", 0, 1, 32'h404, 1, 32'h404, 0, 0, 1);
        check("hold.pred_const", 32'(prediction), 32'd1);
        check("hold.ghr_const", 32'(pred_ghr), 32'h00);
        lookup("post_hold", 32'h400);

        // Randomised traffic with occasional async reset
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 350) mid_reset();
            en   = ($urandom_range(0, 9) != 0);
            lv   = $urandom_range(0, 1) == 1;
            uv   = $urandom_range(0, 1) == 1;
            ut   = $urandom_range(0, 1) == 1;
            um   = $urandom_range(0, 3) == 0;
            lpc  = $urandom & 32'h0000_03FF;
            if ($urandom_range(0, 1) == 1) begin
                upc  = lpc;
                ughr = m_ghr;
            end else begin
                upc  = $urandom;
                ughr = int'($urandom_range(0, MASK));
            end
            cycle("rand", en, lv, lpc, uv, upc, ughr, ut, um);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
